// File: rtl/mesh_term_rx.sv
// mesh_term_rx: drains one mesh output port, filters packets by destination,
// buffers accepted ones in a local FIFO and counts misroutes.
module mesh_term_rx #(
  parameter int pckg_sz = 40,
  parameter int fifo_depth = 4,
  parameter logic [3:0] id_row = 4'd0,
  parameter logic [3:0] id_column = 4'd0,
  parameter logic [7:0] bdcst = {8{1'b1}},
  localparam int CW = $clog2(fifo_depth + 1),
  localparam int PW = $clog2(fifo_depth)
) (
  input  logic clk,
  input  logic reset,
  input  logic pndng,
  input  logic [pckg_sz-1:0] data_in,
  output logic pop,
  output logic rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  output logic rx_bcst,
  input  logic rx_ready,
  output logic [CW-1:0] rx_count,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt,
  output logic err
);
  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;
  state_t state_q, state_d;
  logic cls_v_q, cls_v_d;
  logic [pckg_sz-1:0] cls_q, cls_d;
  logic [pckg_sz:0] mem_q [fifo_depth];
  logic [pckg_sz:0] mem_d [fifo_depth];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] pkt_q, pkt_d, errc_q, errc_d;
  logic err_q, err_d;
  logic is_bc, is_match, wr, rd, mis, credit;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(fifo_depth - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    is_bc = cls_q[pckg_sz-1 -: 8] == bdcst;
    is_match = cls_q[pckg_sz-9 -: 4] == id_row && cls_q[pckg_sz-13 -: 4] == id_column;
    wr = cls_v_q && (is_bc || is_match);
    mis = cls_v_q && !wr;
    rd = cnt_q != '0 && rx_ready;
    // the packet sitting in classify already owns a slot, so reserve it
    credit = {1'b0, cnt_q} + {{CW{1'b0}}, cls_v_q} < (CW + 1)'(fifo_depth);
    state_d = state_q == IDLE ? (pndng && credit ? POP : IDLE) : state_q == POP ? GAP : IDLE;
    cls_v_d = state_q == POP;
    cls_d = state_q == POP ? data_in : cls_q;
    mem_d = mem_q;
    if (wr) mem_d[wp_q] = {is_bc, cls_q};
    wp_d = wr ? nxt(wp_q) : wp_q;
    rp_d = rd ? nxt(rp_q) : rp_q;
    cnt_d = cnt_q + CW'(wr) - CW'(rd);
    pkt_d = wr && pkt_q != 16'hFFFF ? pkt_q + 1'b1 : pkt_q;
    errc_d = mis && errc_q != 16'hFFFF ? errc_q + 1'b1 : errc_q;
    err_d = err_q | mis;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cls_v_q <= 1'b0;
      cls_q <= '0;
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      pkt_q <= '0;
      errc_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_v_q <= cls_v_d;
      cls_q <= cls_d;
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      pkt_q <= pkt_d;
      errc_q <= errc_d;
      err_q <= err_d;
    end
  end

  assign pop = state_q == POP;
  assign rx_valid = cnt_q != '0;
  assign rx_data = rx_valid ? mem_q[rp_q][pckg_sz-1:0] : '0;
  assign rx_bcst = rx_valid ? mem_q[rp_q][pckg_sz] : 1'b0;
  assign rx_count = cnt_q;
  assign pkt_cnt = pkt_q;
  assign err_cnt = errc_q;
  assign err = err_q;
endmodule

// File: tb/tb_mesh_term_rx.sv
// tb_mesh_term_rx: mesh FIFO model feeding the receiver, scoreboard on the
// consumer side, table of classify cases plus multi-cycle corner sequences.
module tb_mesh_term_rx;
  localparam int W = 40;
  localparam int D = 4;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic reset, pndng, pop, rx_valid, rx_bcst, rx_ready, err;
  logic [W-1:0] data_in, rx_data;
  logic [CW-1:0] rx_count;
  logic [15:0] pkt_cnt, err_cnt;

  mesh_term_rx #(.pckg_sz(W), .fifo_depth(D), .id_row(4'd1), .id_column(4'd2)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .data_in(data_in), .pop(pop),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_bcst(rx_bcst), .rx_ready(rx_ready),
    .rx_count(rx_count), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] pkt;
    logic acc;
    logic bcst;
  } vec_t;

  vec_t tbl [7];
  logic [W-1:0] mesh_q [$];
  logic [W:0] exp_q [$];
  int n_cmp = 0, n_fail = 0;
  int exp_pkt = 0, exp_err = 0, pops = 0, max_cnt = 0;
  logic pop_seen, valid_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive();
    pndng = mesh_q.size() != 0;
    data_in = pndng ? mesh_q[0] : '0;
  endtask

  task automatic add(input logic [W-1:0] p, input logic acc, input logic bc);
    mesh_q.push_back(p);
    if (acc) begin
      exp_q.push_back({bc, p});
      exp_pkt++;
    end else exp_err++;
  endtask

  task automatic step();
    logic [W:0] e;
    @(negedge clk);
    pop_seen = pop;
    valid_seen = rx_valid;
    if (int'(rx_count) > max_cnt) max_cnt = int'(rx_count);
    if (rx_valid && rx_ready) begin
      if (exp_q.size() == 0) check("unexpected_rx", {24'd0, rx_data}, 64'hDEAD);
      else begin
        e = exp_q.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, e[W-1:0]});
        check("rx_bcst", {63'd0, rx_bcst}, {63'd0, e[W]});
      end
    end
    @(posedge clk);
    #1;
    if (pop_seen) begin
      pops++;
      if (mesh_q.size() != 0) mesh_q.delete(0);
    end
    drive();
  endtask

  task automatic drain();
    int g = 0;
    while ((mesh_q.size() != 0 || exp_q.size() != 0) && g < 400) begin
      step();
      g++;
    end
    if (g >= 400) check("drain_timeout", 64'd1, 64'd0);
    repeat (6) step();
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_pkt_cnt"}, {48'd0, pkt_cnt}, 64'(exp_pkt));
    check({tag, "_err_cnt"}, {48'd0, err_cnt}, 64'(exp_err));
    check({tag, "_err"}, {63'd0, err}, {63'd0, exp_err != 0});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pop"}, {63'd0, pop}, 64'd0);
    check({tag, "_rx_valid"}, {63'd0, rx_valid}, 64'd0);
    check({tag, "_rx_data"}, {24'd0, rx_data}, 64'd0);
    check({tag, "_rx_bcst"}, {63'd0, rx_bcst}, 64'd0);
    check({tag, "_rx_count"}, 64'(rx_count), 64'd0);
    check({tag, "_pkt_cnt"}, {48'd0, pkt_cnt}, 64'd0);
    check({tag, "_err_cnt"}, {48'd0, err_cnt}, 64'd0);
    check({tag, "_err"}, {63'd0, err}, 64'd0);
  endtask

  initial begin
    int first_pop, first_valid, g;
    tbl[0] = '{40'hFF00000005, 1'b1, 1'b1};
    tbl[1] = '{40'h0033000007, 1'b0, 1'b0};
    tbl[2] = '{40'h0012800003, 1'b1, 1'b0};
    tbl[3] = '{40'hFF12800009, 1'b1, 1'b1};
    tbl[4] = '{40'h0013000011, 1'b0, 1'b0};
    tbl[5] = '{40'h0002000013, 1'b0, 1'b0};
    tbl[6] = '{40'h0012000015, 1'b1, 1'b0};
    reset = 1'b1;
    rx_ready = 1'b0;
    pndng = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    add(40'h0012800001, 1'b1, 1'b0);
    drive();
    first_pop = -1;
    first_valid = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (pop_seen && first_pop < 0) first_pop = i;
      if (valid_seen && first_valid < 0) first_valid = i;
    end
    check("lat_pop_cycle", 64'(first_pop), 64'd1);
    check("lat_valid_cycle", 64'(first_valid), 64'd3);
    check("lat_pops", 64'(pops), 64'd1);
    check("lat_rx_data", {24'd0, rx_data}, 64'h0012800001);
    check("lat_rx_bcst", {63'd0, rx_bcst}, 64'd0);
    check_counters("lat");
    rx_ready = 1'b1;
    drain();
    for (int i = 0; i < 7; i++) begin
      add(tbl[i].pkt, tbl[i].acc, tbl[i].bcst);
      drive();
      drain();
      check_counters($sformatf("tbl%0d", i));
    end
    rx_ready = 1'b0;
    pops = 0;
    for (int i = 0; i < 6; i++) add(40'h0012800100 | 40'(i), 1'b1, 1'b0);
    drive();
    repeat (40) step();
    check("bp_pops", 64'(pops), 64'd4);
    check("bp_rx_count", 64'(rx_count), 64'd4);
    check("bp_pop_held", {63'd0, pop_seen}, 64'd0);
    rx_ready = 1'b1;
    drain();
    check("bp_total_pops", 64'(pops), 64'd6);
    check_counters("bp");
    max_cnt = 0;
    for (int i = 0; i < 8; i++) add(40'hFF00000200 | 40'(i), 1'b1, 1'b1);
    drive();
    drain();
    check("stream_max_count", 64'(max_cnt), 64'd1);
    check_counters("stream");
    add(40'h0012800300, 1'b1, 1'b0);
    drive();
    g = 0;
    @(negedge clk);
    while (!pop && g < 20) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      g++;
    end
    check("mid_pop_seen", {63'd0, pop}, 64'd1);
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    exp_pkt = 1;
    exp_err = 0;
    pops = 0;
    drive();
    drain();
    check("midrst_pops", 64'(pops), 64'd1);
    check_counters("midrst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
